// File: rtl/tw_ram_writer.sv
// Twiddle table writer: fills N=2^LOGN RAM words with init*w^k mod q using a bit-serial modular multiplier.
// Define TW_BITREV_ADDR_EN to write in bit-reversed address order instead of natural order.
module tw_ram_writer #(
    parameter int LOGN = 3,
    parameter int LOGQ = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [LOGQ-1:0] q,
    input  logic [LOGQ-1:0] w,
    input  logic [LOGQ-1:0] init,
    output logic            wen,
    output logic [LOGN-1:0] waddr,
    output logic [LOGQ-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int BW = (LOGQ > 1) ? $clog2(LOGQ) : 1;

    typedef enum logic [2:0] {IDLE, CHECK, WRITE, MUL, DONE} state_t;

    state_t          state, state_nx;
    logic [LOGQ-1:0] q_r, w_r, cur;
    logic [LOGQ:0]   acc;
    logic [LOGN-1:0] k;
    logic [BW-1:0]   bit_idx;

    logic [LOGQ:0]   qx, dbl, red1, sum, step;
    logic            bad;

    function automatic logic [LOGN-1:0] addr_of(input logic [LOGN-1:0] idx);
`ifdef TW_BITREV_ADDR_EN
        logic [LOGN-1:0] r;
        for (int b = 0; b < LOGN; b++) r[b] = idx[LOGN-1-b];
        return r;
`else
        return idx;
`endif
    endfunction

    // One MSB-first step: double-and-reduce, then conditionally add cur and reduce.
    always_comb begin
        qx   = {1'b0, q_r};
        dbl  = {acc[LOGQ-1:0], 1'b0};
        red1 = (dbl >= qx) ? dbl - qx : dbl;
        sum  = red1 + {1'b0, cur};
        step = red1;
        if (w_r[bit_idx]) step = (sum >= qx) ? sum - qx : sum;
    end

    assign bad = (q_r < LOGQ'(2)) || (w_r >= q_r) || (cur >= q_r);

    always_comb begin
        state_nx = state;
        wen      = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:  if (start) state_nx = CHECK;
            CHECK: begin
                busy     = 1'b1;
                state_nx = bad ? DONE : WRITE;
            end
            WRITE: begin
                busy     = 1'b1;
                wen      = 1'b1;
                state_nx = (&k) ? DONE : MUL;
            end
            MUL: begin
                busy = 1'b1;
                if (bit_idx == '0) state_nx = WRITE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            q_r     <= '0;
            w_r     <= '0;
            cur     <= '0;
            acc     <= '0;
            k       <= '0;
            bit_idx <= '0;
            waddr   <= '0;
            wdata   <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    q_r <= q;
                    w_r <= w;
                    cur <= init;
                    err <= 1'b0;
                end
                CHECK: if (bad) begin
                    err <= 1'b1;
                end else begin
                    k     <= '0;
                    waddr <= addr_of('0);
                    wdata <= cur;
                end
                WRITE: begin
                    acc     <= '0;
                    bit_idx <= BW'(LOGQ - 1);
                end
                MUL: begin
                    acc     <= step;
                    bit_idx <= bit_idx - 1'b1;
                    // Last multiplier step: stage the next entry for the following WRITE.
                    if (bit_idx == '0) begin
                        cur   <= step[LOGQ-1:0];
                        k     <= k + 1'b1;
                        waddr <= addr_of(k + 1'b1);
                        wdata <= step[LOGQ-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tw_ram_writer.sv
// Bench for tw_ram_writer: an 8-bit and a 64-bit instance, scoreboard of expected RAM writes checked on every wen.
module tb_tw_ram_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        st8 = 1'b0, st64 = 1'b0;
    logic [7:0]  q8 = '0, w8 = '0, i8 = '0;
    logic [63:0] q64 = '0, w64 = '0, i64 = '0;
    logic        wen8, busy8, done8, err8, wen64, busy64, done64, err64;
    logic [1:0]  wa8, wa64;
    logic [7:0]  wd8;
    logic [63:0] wd64;

    tw_ram_writer #(.LOGN(2), .LOGQ(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .q(q8), .w(w8), .init(i8),
        .wen(wen8), .waddr(wa8), .wdata(wd8), .busy(busy8), .done(done8), .err(err8));

    tw_ram_writer #(.LOGN(2), .LOGQ(64)) dut64 (
        .clk(clk), .rst(rst), .start(st64), .q(q64), .w(w64), .init(i64),
        .wen(wen64), .waddr(wa64), .wdata(wd64), .busy(busy64), .done(done64), .err(err64));

    typedef struct {
        int          cyc;
        logic [1:0]  addr;
        logic [63:0] data;
    } exp_t;

    exp_t sb8[$];
    exp_t sb64[$];
    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0, t0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mulmod(input logic [63:0] a, b, m);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        return 64'(p % {64'd0, m});
    endfunction

    function automatic logic [1:0] tb_addr(input int k);
        logic [1:0] kk;
        kk = 2'(k);
`ifdef TW_BITREV_ADDR_EN
        return {kk[0], kk[1]};
`else
        return kk;
`endif
    endfunction

    task automatic mon(input bit big, input logic [1:0] a, input logic [63:0] d);
        exp_t e;
        if (big ? (sb64.size() == 0) : (sb8.size() == 0)) begin
            chk(big ? "unexpected_wen64" : "unexpected_wen8", 1, 0);
        end else begin
            e = big ? sb64.pop_front() : sb8.pop_front();
            chk(big ? "waddr64" : "waddr8", a, e.addr);
            chk(big ? "wdata64" : "wdata8", d, e.data);
            chk(big ? "wcycle64" : "wcycle8", cyc - t0 + 1, e.cyc);
        end
    endtask

    always @(negedge clk) if (wen8) mon(1'b0, wa8, {56'd0, wd8});
    always @(negedge clk) if (wen64) mon(1'b1, wa64, wd64);

    task automatic chk_zero(input bit big, input string tag);
        chk({tag, "_wen"},   big ? wen64 : wen8, 0);
        chk({tag, "_waddr"}, big ? wa64 : wa8, 0);
        chk({tag, "_wdata"}, big ? wd64 : {56'd0, wd8}, 0);
        chk({tag, "_busy"},  big ? busy64 : busy8, 0);
        chk({tag, "_done"},  big ? done64 : done8, 0);
        chk({tag, "_err"},   big ? err64 : err8, 0);
    endtask

    // One run: build expected writes, pulse start, follow busy/err/done cycle by cycle.
    task automatic run(input bit big, input logic [63:0] qv, wv, iv,
                       input bit poke, input int abort_at);
        int          L;
        int          exp_done;
        bit          bad, seen;
        logic [63:0] cur;
        exp_t        e;
        L   = big ? 64 : 8;
        bad = (qv < 2) || (wv >= qv) || (iv >= qv);
        cur = iv;
        if (!bad) begin
            for (int k = 0; k < 4; k++) begin
                e.cyc = 2 + k * (L + 1); e.addr = tb_addr(k); e.data = cur;
                if (big) sb64.push_back(e); else sb8.push_back(e);
                cur = mulmod(cur, wv, qv);
            end
        end
        exp_done = bad ? 2 : 2 + 3 * (L + 1) + 1;
        @(negedge clk);
        if (big) begin q64 = qv; w64 = wv; i64 = iv; st64 = 1'b1; end
        else begin q8 = qv[7:0]; w8 = wv[7:0]; i8 = iv[7:0]; st8 = 1'b1; end
        @(posedge clk);
        #1;
        st8 = 1'b0; st64 = 1'b0; t0 = cyc;
        // Scramble inputs: the run must use latched values.
        q8 = 8'h03; w8 = 8'h01; i8 = 8'hff; q64 = 64'd5; w64 = 64'd2; i64 = '1;
        seen = 1'b0;
        for (int n = 1; n <= exp_done + 20; n++) begin
            @(negedge clk);
            if (poke) begin
                if (n == 5) begin st8 = !big; st64 = big; end
                if (n == 6) begin st8 = 1'b0; st64 = 1'b0; end
            end
            if (abort_at != 0 && n == abort_at) begin
                rst = 1'b1;
                #1;
                chk_zero(big, "abort");
                sb8.delete(); sb64.delete();
                #2 rst = 1'b0;
                return;
            end
            if (big ? done64 : done8) begin
                chk("done_cycle", n, exp_done);
                chk("err_at_done", big ? err64 : err8, bad);
                chk("busy_at_done", big ? busy64 : busy8, 0);
                seen = 1'b1;
                break;
            end else begin
                chk("busy_run", big ? busy64 : busy8, 1);
                chk("err_run", big ? err64 : err8, 0);
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("done_pulse", big ? done64 : done8, 0);
        chk("writes_left", big ? sb64.size() : sb8.size(), 0);
        repeat (3) @(negedge clk);
        chk("err_hold", big ? err64 : err8, bad);
        chk("idle_busy", big ? busy64 : busy8, 0);
        chk("idle_wen", big ? wen64 : wen8, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_zero(1'b0, "rst8");
        chk_zero(1'b1, "rst64");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(1'b0, 64'd17, 64'd3,  64'd1,  1'b0, 0);   // 1,3,9,10
        run(1'b0, 64'd17, 64'd16, 64'd16, 1'b0, 0);   // 16,1,16,1
        run(1'b0, 64'd17, 64'd0,  64'd1,  1'b0, 0);   // 1,0,0,0
        run(1'b0, 64'd17, 64'd17, 64'd1,  1'b0, 0);   // w>=q error
        run(1'b0, 64'd17, 64'd3,  64'd17, 1'b0, 0);   // init>=q error
        run(1'b0, 64'd1,  64'd0,  64'd0,  1'b0, 0);   // q<2 error
        run(1'b0, 64'd251, 64'd200, 64'd123, 1'b0, 0);
        run(1'b0, 64'd17, 64'd3,  64'd1,  1'b1, 0);   // start while busy ignored
        run(1'b0, 64'd17, 64'd3,  64'd1,  1'b0, 12);  // reset after 2nd write
        run(1'b0, 64'd17, 64'd3,  64'd1,  1'b0, 0);   // replay after abort
        run(1'b1, 64'hFFFF_FFFF_FFFF_FFC5, 64'hFFFF_FFFF_FFFF_FFC4,
            64'hFFFF_FFFF_FFFF_FFC4, 1'b0, 0);
        run(1'b1, 64'hFFFF_FFFF_FFFF_FFC5, 64'h0123_4567_89AB_CDEF,
            64'hFEDC_BA98_7654_3210, 1'b0, 0);
        for (int r = 0; r < 4; r++) begin
            logic [63:0] qr, wr, ir;
            qr = 64'($urandom_range(2, 255));
            wr = 64'($urandom_range(0, 255)) % qr;
            ir = 64'($urandom_range(0, 255)) % qr;
            run(1'b0, qr, wr, ir, 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
